// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: instruction classes, immediate formats,
// major opcodes and instruction field positions.
package rv32i_pkg;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_LUI     = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_OP_IMM  = 4'd8,
        CLS_OP_REG  = 4'd9,
        CLS_FENCE   = 4'd10,
        CLS_SYSTEM  = 4'd11
    } op_class_t;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP_REG = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int unsigned RD_LSB   = 7;
    localparam int unsigned F3_LSB   = 12;
    localparam int unsigned RS1_LSB  = 15;
    localparam int unsigned RS2_LSB  = 20;
    localparam int unsigned F7B5_BIT = 30;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediate and sign-extends it
// from instr[31] to XLEN.
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  imm_fmt_t        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt_i)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: opcode decode, busy-bit RAW scoreboard, rs1 read-port
// steering and the registered bundle handed to execute.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_select,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output op_class_t       out_class,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush
);

    op_class_t       cls;
    imm_fmt_t        fmt;
    logic            uses_rs1, uses_rs2, rd_capable, writes_rd, illegal;
    logic [4:0]      rd_f, rs1_f, rs2_f;
    logic [XLEN-1:0] imm;

    always_comb begin
        cls        = CLS_ILLEGAL;
        fmt        = IMM_NONE;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        rd_capable = 1'b0;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                OPC_LUI:    begin cls = CLS_LUI;    fmt = IMM_U; rd_capable = 1'b1; end
                OPC_AUIPC:  begin cls = CLS_AUIPC;  fmt = IMM_U; rd_capable = 1'b1; end
                OPC_JAL:    begin cls = CLS_JAL;    fmt = IMM_J; rd_capable = 1'b1; end
                OPC_JALR:   begin cls = CLS_JALR;   fmt = IMM_I; rd_capable = 1'b1; uses_rs1 = 1'b1; end
                OPC_BRANCH: begin cls = CLS_BRANCH; fmt = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OPC_LOAD:   begin cls = CLS_LOAD;   fmt = IMM_I; rd_capable = 1'b1; uses_rs1 = 1'b1; end
                OPC_STORE:  begin cls = CLS_STORE;  fmt = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OPC_OP_IMM: begin cls = CLS_OP_IMM; fmt = IMM_I; rd_capable = 1'b1; uses_rs1 = 1'b1; end
                OPC_OP_REG: begin cls = CLS_OP_REG; fmt = IMM_NONE; rd_capable = 1'b1;
                                  uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OPC_FENCE:  begin cls = CLS_FENCE;  fmt = IMM_I; end
                OPC_SYSTEM: begin cls = CLS_SYSTEM; fmt = IMM_I; end
                default:    cls = CLS_ILLEGAL;
            endcase
        end
    end

    assign illegal   = (cls == CLS_ILLEGAL);
    assign rd_f      = illegal ? 5'd0 : in_instr[RD_LSB +: 5];
    assign rs1_f     = in_instr[RS1_LSB +: 5];
    assign rs2_f     = in_instr[RS2_LSB +: 5];
    assign writes_rd = rd_capable & (rd_f != 5'd0);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

    // The hazard looks at busy after this cycle's writeback clear, so the
    // retiring producer releases its consumer in the same cycle.
    logic [31:0] busy_q, busy_d, busy_wb, clr_mask, set_mask;
    logic        hazard, in_fire, out_valid_q, out_valid_d;

    assign clr_mask = wb_valid ? (32'd1 << wb_rd) : '0;
    assign busy_wb  = busy_q & ~clr_mask;
    assign hazard   = (uses_rs1 & busy_wb[rs1_f]) | (uses_rs2 & busy_wb[rs2_f]);
    assign in_ready = reset & ~flush & ~hazard & (~out_valid_q | out_ready);
    assign in_fire  = in_valid & in_ready;
    assign set_mask = (in_fire & writes_rd) ? (32'd1 << rd_f) : '0;

    always_comb begin
        busy_d      = flush ? '0 : ((busy_wb | set_mask) & ~32'd1);
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (in_fire)   out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    logic [XLEN-1:0] out_pc_q, out_imm_q;
    op_class_t       out_class_q;
    logic [4:0]      out_rd_q, out_rs1_q, out_rs2_q;
    logic [2:0]      out_funct3_q;
    logic            out_funct7b5_q, out_illegal_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q         <= '0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_class_q    <= CLS_ILLEGAL;
            out_rd_q       <= '0;
            out_rs1_q      <= '0;
            out_rs2_q      <= '0;
            out_funct3_q   <= '0;
            out_funct7b5_q <= 1'b0;
            out_imm_q      <= '0;
            out_illegal_q  <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            if (in_fire) begin
                out_pc_q       <= in_pc;
                out_class_q    <= cls;
                out_rd_q       <= rd_f;
                out_rs1_q      <= rs1_f;
                out_rs2_q      <= rs2_f;
                out_funct3_q   <= in_instr[F3_LSB +: 3];
                out_funct7b5_q <= in_instr[F7B5_BIT];
                out_imm_q      <= imm;
                out_illegal_q  <= illegal;
            end
        end
    end

    // Steer the read port to the incoming rs1 only when it is actually
    // accepted, so the registered read stays aligned with the held bundle.
    assign rs1_select   = in_fire ? rs1_f : out_rs1_q;

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_class    = out_class_q;
    assign out_rd       = out_rd_q;
    assign out_rs1      = out_rs1_q;
    assign out_rs2      = out_rs2_q;
    assign out_funct3   = out_funct3_q;
    assign out_funct7b5 = out_funct7b5_q;
    assign out_imm      = out_imm_q;
    assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios followed by random
// traffic, checked against an arithmetic reference decoder and busy model.
module tb_decode_stage;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, wb_valid = 1'b0, flush = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic [4:0]  wb_rd = '0;
    logic        in_ready, out_valid, out_funct7b5, out_illegal;
    logic [4:0]  rs1_select, out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [31:0] out_pc, out_imm;
    op_class_t   out_class;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_select(rs1_select),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_imm(out_imm), .out_illegal(out_illegal), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7b5, ill, u1, u2, wr;
        logic [31:0] imm;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] busy_m = '0;
    logic [4:0]  held_rs1 = '0;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: class table by opcode, immediates by arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [31:0] v;
        int fmt; // 0 I, 1 S, 2 B, 3 U, 4 J, 5 none
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12];
        e.f7b5 = ins[30];
        fmt = 5;
        case (ins[6:0])
            7'h37: begin e.cls = 4'd1;  fmt = 3; end
            7'h17: begin e.cls = 4'd2;  fmt = 3; end
            7'h6F: begin e.cls = 4'd3;  fmt = 4; end
            7'h67: begin e.cls = 4'd4;  fmt = 0; end
            7'h63: begin e.cls = 4'd5;  fmt = 2; end
            7'h03: begin e.cls = 4'd6;  fmt = 0; end
            7'h23: begin e.cls = 4'd7;  fmt = 1; end
            7'h13: begin e.cls = 4'd8;  fmt = 0; end
            7'h33: begin e.cls = 4'd9;  fmt = 5; end
            7'h0F: begin e.cls = 4'd10; fmt = 0; end
            7'h73: begin e.cls = 4'd11; fmt = 0; end
            default: e.cls = 4'd0;
        endcase
        e.ill = (e.cls == 4'd0);
        e.rd  = e.ill ? 5'd0 : ins[11:7];
        e.u1  = e.cls inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        e.u2  = e.cls inside {4'd5, 4'd7, 4'd9};
        e.wr  = (e.cls inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9}) && (e.rd != 5'd0);
        case (fmt)
            0: begin v = ins[31:20]; if (ins[31]) v = v - 32'd4096; end
            1: begin v = ins[31:25] * 32 + ins[11:7]; if (ins[31]) v = v - 32'd4096; end
            2: begin v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
                     if (ins[31]) v = v - 32'd8192; end
            3: v = ins & 32'hFFFF_F000;
            4: begin v = ins[31] * (1 << 20) + ins[19:12] * (1 << 12) + ins[20] * 2048
                         + ins[30:21] * 2;
                     if (ins[31]) v = v - (32'd1 << 21); end
            default: v = '0;
        endcase
        e.imm = v;
        return e;
    endfunction

    // One clock cycle: drive at +1, predict and check combinational outputs
    // at +4, then advance the reference state to what the edge will produce.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic ordy, input logic wbv,
                         input logic [4:0] wbr, input logic fl);
        exp_t e;
        logic [31:0] eff;
        logic haz, exp_ov, rdy, fire;
        @(posedge clk); #1;
        reset = rst; in_valid = v; in_instr = ins; in_pc = pc;
        out_ready = fl ? 1'b0 : ordy; wb_valid = wbv; wb_rd = wbr; flush = fl;
        #3;
        if (!rst) begin sbq.delete(); held_rs1 = '0; busy_m = '0; end
        if (fl) e = ref_decode(ins, pc);
        e   = ref_decode(ins, pc);
        eff = busy_m;
        if (wbv) eff[wbr] = 1'b0;
        haz    = (e.u1 && eff[e.rs1]) || (e.u2 && eff[e.rs2]);
        exp_ov = (sbq.size() != 0);
        rdy    = rst && !fl && !haz && (!exp_ov || out_ready);
        fire   = v && rdy;
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("rs1_select", 32'(rs1_select), 32'(fire ? ins[19:15] : held_rs1));
        if (fire) begin sbq.push_back(e); held_rs1 = ins[19:15]; end
        if (!rst || fl) busy_m = '0;
        else begin
            busy_m = eff;
            if (fire && e.wr) busy_m[e.rd] = 1'b1;
        end
        busy_m[0] = 1'b0;
        if (fl) sbq.delete();
    endtask

    // Monitor: compares every bundle execute consumes against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_checks++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL spurious_out: got bundle pc %h expected none", out_pc);
                end else begin
                    e = sbq.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_class", 32'(out_class), 32'(e.cls));
                    check("out_rd", 32'(out_rd), 32'(e.rd));
                    check("out_rs1", 32'(out_rs1), 32'(e.rs1));
                    check("out_rs2", 32'(out_rs2), 32'(e.rs2));
                    check("out_funct3", 32'(out_funct3), 32'(e.f3));
                    check("out_funct7b5", 32'(out_funct7b5), 32'(e.f7b5));
                    check("out_imm", out_imm, e.imm);
                    check("out_illegal", 32'(out_illegal), 32'(e.ill));
                end
            end
        end
    end

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] ins;
        int unsigned sel;
        sel = $urandom_range(0, 12);
        ins = $urandom;
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        if (sel < 11) ins[6:0] = ops[sel];
        else if (sel == 12) ins[1:0] = 2'($urandom_range(0, 2));
        return ins;
    endfunction

    initial begin
        logic [4:0] cand[$];
        logic       wbv;
        logic [4:0] wbr;

        cycle(0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_class", 32'(out_class), 32'h0);
        check("rst_out_imm", out_imm, 32'h0);
        cycle(0, 1, 32'hFFF00293, 32'h4, 1, 0, 0, 0);

        // Plain decode, then RAW stall on x5 released by writeback.
        cycle(1, 1, 32'hFFF00293, 32'h100, 1, 0, 0, 0);
        cycle(1, 1, 32'h00528333, 32'h104, 1, 0, 0, 0);
        check("addi_imm", out_imm, 32'hFFFF_FFFF);
        check("addi_rd", 32'(out_rd), 32'd5);
        check("addi_class", 32'(out_class), 32'(CLS_OP_IMM));
        cycle(1, 1, 32'h00528333, 32'h104, 1, 0, 0, 0);
        cycle(1, 1, 32'h00528333, 32'h104, 1, 0, 0, 0);
        cycle(1, 1, 32'h00528333, 32'h104, 1, 1, 5'd5, 0);
        check("raw_release_sel", 32'(rs1_select), 32'd5);

        // Backpressure with the next instruction waiting.
        cycle(1, 1, 32'h00100093, 32'h108, 0, 0, 0, 0);
        cycle(1, 1, 32'h00100093, 32'h108, 0, 0, 0, 0);
        cycle(1, 1, 32'h00100093, 32'h108, 0, 0, 0, 0);
        cycle(1, 1, 32'h00100093, 32'h108, 1, 0, 0, 0);

        // Set/clear collision on x7, then a reader of x7 must stall.
        cycle(1, 1, 32'h111113B7, 32'h10C, 1, 0, 0, 0);
        cycle(1, 1, 32'h123453B7, 32'h110, 1, 1, 5'd7, 0);
        cycle(1, 1, 32'h00038413, 32'h114, 1, 0, 0, 0);
        check("lui_imm", out_imm, 32'h1234_5000);
        cycle(1, 1, 32'h00038413, 32'h114, 1, 1, 5'd7, 0);

        // Illegal word and x0 destination.
        cycle(1, 1, 32'h00000000, 32'h118, 1, 0, 0, 0);
        cycle(1, 1, 32'h00000013, 32'h11C, 1, 0, 0, 0);
        check("illegal_flag", 32'(out_illegal), 32'd1);
        check("illegal_rd", 32'(out_rd), 32'd0);
        cycle(1, 1, 32'h000004B3, 32'h120, 1, 0, 0, 0);
        cycle(1, 1, 32'h00000033, 32'h124, 1, 0, 0, 0);

        // Flush with a held bundle and busy x3; reader of x3 then proceeds.
        cycle(1, 1, 32'h000011B7, 32'h128, 0, 0, 0, 0);
        cycle(1, 1, 32'h00018213, 32'h12C, 0, 1, 5'd3, 1);
        cycle(1, 1, 32'h00018213, 32'h12C, 1, 0, 0, 0);

        // Reset asserted mid-stall takes effect without a clock edge.
        cycle(1, 1, 32'h000052B7, 32'h130, 1, 0, 0, 0);
        cycle(1, 1, 32'h00028313, 32'h134, 1, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd0);
        check("async_rs1_select", 32'(rs1_select), 32'd0);
        check("async_out_rd", 32'(out_rd), 32'd0);
        check("async_out_imm", out_imm, 32'd0);
        sbq.delete(); busy_m = '0; held_rs1 = '0;
        cycle(0, 1, 32'h00028313, 32'h134, 1, 0, 0, 0);
        cycle(1, 1, 32'h00028313, 32'h134, 1, 0, 0, 0);

        // Random traffic with writebacks drawn from outstanding writers.
        for (int i = 0; i < 1500; i++) begin
            cand.delete();
            for (int r = 1; r < 32; r++) if (busy_m[r]) cand.push_back(5'(r));
            wbv = 1'b0; wbr = 5'($urandom_range(0, 31));
            if (cand.size() != 0 && $urandom_range(0, 99) < 40) begin
                wbv = 1'b1;
                wbr = cand[$urandom_range(0, cand.size() - 1)];
            end
            cycle(1, ($urandom_range(0, 99) < 80), gen_instr(), $urandom,
                  ($urandom_range(0, 99) < 75), wbv, wbr, ($urandom_range(0, 99) < 2));
        end

        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        check("queue_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
